robot_cmd_arbiter: RTL and testbench
====================================

Name: robot_cmd_arbiter

Overview:
- Arbitrates robot motion commands from three requesters: the IR remote decoder (data/data_en/repeat_en), the Bluetooth UART command decoder, and the autonomous (line/obstacle) logic.
- Produces one registered motion command plus the SG90 enable for the motor driver and servo blocks.
- Sits between the IR receive path and the motor/servo drivers. It replaces per-key level outputs with a single owned command that has a hold timeout.

Parameters:
- CLK_FREQ, 50_000_000, system clock in Hz.
- IR_HOLD_MS, 120, time an IR command stays active after its last frame or repeat; must exceed the NEC repeat period of 108 ms.
- BT_HOLD_MS, 1000, watchdog on a latched Bluetooth command.
- TMR_W, 26, hold-timer width; must hold CLK_FREQ/1000*BT_HOLD_MS.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ir_data  in  8  NEC command byte, valid with ir_data_en
- ir_data_en  in  1  one-cycle pulse: new IR frame decoded
- ir_repeat_en  in  1  one-cycle pulse: NEC repeat frame
- bt_code  in  8  Bluetooth command byte, valid with bt_valid
- bt_valid  in  1  one-cycle pulse
- auto_en  in  1  level: autonomous mode enabled
- auto_cmd  in  4  motion code from autonomous logic
- motion_cmd  out  4  registered motion code
- cmd_src  out  2  current owner: 0 none, 1 auto, 2 bt, 3 ir
- cmd_strobe  out  1  one-cycle pulse when motion_cmd or cmd_src changes
- sg90_en  out  1  servo enable, toggled by the IR/BT power code

Behaviour:
- Reset (async, rst_n=0): state IDLE, motion_cmd=STOP(0), cmd_src=0, cmd_strobe=0, sg90_en=0, timer=0.
- Motion codes: STOP=0, FWD=1, BACK=2, LEFT=3, RIGHT=4; 5–15 reserved.
- IR decode: 0x18→FWD, 0x52→BACK, 0x08→LEFT, 0x5A→RIGHT, 0x1C→STOP, 0x45→SERVO_TOGGLE.
- BT decode: ASCII 'F','B','L','R','S' map to FWD/BACK/LEFT/RIGHT/STOP; 'P'→SERVO_TOGGLE.
- Any other byte is ignored: no state change, no strobe.
- States: IDLE (src 0), AUTO (src 1), BT_HOLD (src 2), IR_HOLD (src 3). Priority is IR > BT > AUTO.
- Any state, valid IR motion code on ir_data_en → IR_HOLD; motion_cmd=decoded code; timer loaded with IR_HOLD_MS cycles.
- IR_HOLD: ir_repeat_en reloads the timer and keeps motion_cmd.
- ir_repeat_en outside IR_HOLD is ignored.
- IR_HOLD: bt_valid is dropped, not queued.
- Not IR_HOLD, valid BT motion code → BT_HOLD; timer loaded with BT_HOLD_MS cycles.
- BT_HOLD: a new BT code replaces the command and reloads the timer.
- Same cycle ir_data_en and bt_valid both valid → IR wins; the BT byte is discarded.
- Timer decrements once per clk in IR_HOLD/BT_HOLD. On reaching 0 → AUTO if auto_en, else IDLE.
- IDLE and auto_en=1 → AUTO next cycle. AUTO and auto_en=0 → IDLE.
- AUTO: motion_cmd follows auto_cmd registered, 1-cycle latency.
- IDLE: motion_cmd=STOP.
- SERVO_TOGGLE: inverts sg90_en on ir_data_en or bt_valid only; repeats never toggle. It changes neither state nor timer. In IR_HOLD, BT 'P' is dropped like any BT byte.
- Latency: valid pulse at cycle N → motion_cmd/cmd_src updated at N+1, cmd_strobe high at N+1 only.
- Re-issuing an identical code reloads the timer but gives no strobe.
- Reset asserted mid-hold: immediate return to reset values. No command survives reset.

Decomposition:
- Package robot_cmd_pkg: motion-code constants, IR and BT code constants, state encoding, src encoding, and the ms-to-cycles constant function.
- One sub-module, cmd_hold_timer: loadable down-counter with load, load value, and expired output, used for both hold windows.

Test Plan:
- Reset, auto_en=0 → motion_cmd=0, cmd_src=0, sg90_en=0; no strobe.
- ir_data=0x18 pulse → FWD, src=3 next cycle, strobe 1 cycle; no repeats → STOP, src=0 after exactly IR_HOLD cycles (sim: CLK_FREQ=1000, IR_HOLD_MS=5 → 5 cycles).
- IR FWD, then ir_repeat_en every 4 cycles ×3 → FWD held throughout; returns to 0 five cycles after the last repeat.
- bt 'L' then same-cycle ir 0x5A and bt 'B' → RIGHT, src=3; BT 'B' lost; after IR timeout with auto_en=1, auto_cmd=2 → motion 2, src=1.
- IR 0x45 then 3 repeats → sg90_en=1 (single toggle); bt 'P' in IDLE → sg90_en=0; motion unchanged.
- Unknown bytes ir 0x99 / bt 'Z' → no change, no strobe; rst_n low during BT_HOLD → outputs 0 asynchronously.

Source files
------------

// File: rtl/robot_cmd_pkg.sv
// Shared encodings for the robot command arbiter: motion codes, IR/BT key bytes,
// ownership states and the decode helpers used by the arbiter.
package robot_cmd_pkg;

  localparam logic [3:0] MOT_STOP  = 4'd0;
  localparam logic [3:0] MOT_FWD   = 4'd1;
  localparam logic [3:0] MOT_BACK  = 4'd2;
  localparam logic [3:0] MOT_LEFT  = 4'd3;
  localparam logic [3:0] MOT_RIGHT = 4'd4;

  localparam logic [7:0] IR_FWD    = 8'h18;
  localparam logic [7:0] IR_BACK   = 8'h52;
  localparam logic [7:0] IR_LEFT   = 8'h08;
  localparam logic [7:0] IR_RIGHT  = 8'h5A;
  localparam logic [7:0] IR_STOP   = 8'h1C;
  localparam logic [7:0] IR_SERVO  = 8'h45;

  localparam logic [7:0] BT_FWD    = 8'h46; // 'F'
  localparam logic [7:0] BT_BACK   = 8'h42; // 'B'
  localparam logic [7:0] BT_LEFT   = 8'h4C; // 'L'
  localparam logic [7:0] BT_RIGHT  = 8'h52; // 'R'
  localparam logic [7:0] BT_STOP   = 8'h53; // 'S'
  localparam logic [7:0] BT_SERVO  = 8'h50; // 'P'

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_AUTO = 2'd1;
  localparam logic [1:0] SRC_BT   = 2'd2;
  localparam logic [1:0] SRC_IR   = 2'd3;

  // State encoding equals the owner code so cmd_src is the state register itself.
  typedef enum logic [1:0] {
    ST_IDLE    = SRC_NONE,
    ST_AUTO    = SRC_AUTO,
    ST_BT_HOLD = SRC_BT,
    ST_IR_HOLD = SRC_IR
  } state_t;

  typedef struct packed {
    logic       valid;
    logic       toggle;
    logic [3:0] motion;
  } cmd_dec_t;

  function automatic int unsigned ms_to_cycles(input int unsigned clk_freq,
                                               input int unsigned ms);
    return clk_freq / 1000 * ms;
  endfunction

  function automatic cmd_dec_t decode_ir(input logic [7:0] code);
    cmd_dec_t d;
    d = '{valid: 1'b1, toggle: 1'b0, motion: MOT_STOP};
    case (code)
      IR_FWD:   d.motion = MOT_FWD;
      IR_BACK:  d.motion = MOT_BACK;
      IR_LEFT:  d.motion = MOT_LEFT;
      IR_RIGHT: d.motion = MOT_RIGHT;
      IR_STOP:  d.motion = MOT_STOP;
      IR_SERVO: d.toggle = 1'b1;
      default:  d.valid  = 1'b0;
    endcase
    return d;
  endfunction

  function automatic cmd_dec_t decode_bt(input logic [7:0] code);
    cmd_dec_t d;
    d = '{valid: 1'b1, toggle: 1'b0, motion: MOT_STOP};
    case (code)
      BT_FWD:   d.motion = MOT_FWD;
      BT_BACK:  d.motion = MOT_BACK;
      BT_LEFT:  d.motion = MOT_LEFT;
      BT_RIGHT: d.motion = MOT_RIGHT;
      BT_STOP:  d.motion = MOT_STOP;
      BT_SERVO: d.toggle = 1'b1;
      default:  d.valid  = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/robot_cmd_arbiter_cmd_hold_timer.sv
// Loadable hold-window down-counter; o_expired flags the cycle in which the
// count reaches zero so the owner can be released on the following edge.
module cmd_hold_timer #(
  parameter int TMR_W = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [TMR_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_expired
);

  logic [TMR_W-1:0] r_count;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - TMR_W'(1);
    end
  end

  assign o_expired = (r_count == '0) || (r_count == TMR_W'(1));

endmodule

// File: rtl/robot_cmd_arbiter.sv
// Owns the single robot motion command: IR beats BT beats autonomous, with
// hold timeouts for the remote sources and a servo-enable toggle.
module robot_cmd_arbiter
  import robot_cmd_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int IR_HOLD_MS = 120,
  parameter int BT_HOLD_MS = 1000,
  parameter int TMR_W      = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ir_data,
  input  logic       ir_data_en,
  input  logic       ir_repeat_en,
  input  logic [7:0] bt_code,
  input  logic       bt_valid,
  input  logic       auto_en,
  input  logic [3:0] auto_cmd,
  output logic [3:0] motion_cmd,
  output logic [1:0] cmd_src,
  output logic       cmd_strobe,
  output logic       sg90_en
);

  localparam logic [TMR_W-1:0] IR_LOAD = TMR_W'(ms_to_cycles(CLK_FREQ, IR_HOLD_MS));
  localparam logic [TMR_W-1:0] BT_LOAD = TMR_W'(ms_to_cycles(CLK_FREQ, BT_HOLD_MS));

  state_t           r_state;
  logic [3:0]       r_motion;
  logic             r_strobe;
  logic             r_sg90;

  state_t           w_next_state;
  logic [3:0]       w_next_motion;
  logic             w_next_sg90;
  logic             w_load;
  logic [TMR_W-1:0] w_load_val;
  logic             w_dec;
  logic             w_expired;
  cmd_dec_t         w_ir;
  cmd_dec_t         w_bt;
  logic             w_ir_hit;
  logic             w_bt_hit;

  assign w_ir = decode_ir(ir_data);
  assign w_bt = decode_bt(bt_code);

  // A recognised IR byte in the same cycle discards BT; IR ownership blocks BT entirely.
  assign w_ir_hit = ir_data_en & w_ir.valid;
  assign w_bt_hit = bt_valid & w_bt.valid & ~w_ir_hit & (r_state != ST_IR_HOLD);

  cmd_hold_timer #(
    .TMR_W(TMR_W)
  ) u_hold_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_expired  (w_expired)
  );

  // NOTE: every signal gets a default before any branch, so no path infers a latch.
  always_comb begin
    w_next_state  = r_state;
    w_next_motion = r_motion;
    w_load        = 1'b0;
    w_load_val    = IR_LOAD;
    w_dec         = 1'b0;
    w_next_sg90   = r_sg90 ^ ((w_ir_hit & w_ir.toggle) | (w_bt_hit & w_bt.toggle));

    if (w_ir_hit && !w_ir.toggle) begin
      w_next_state  = ST_IR_HOLD;
      w_next_motion = w_ir.motion;
      w_load        = 1'b1;
      w_load_val    = IR_LOAD;
    end else if (w_bt_hit && !w_bt.toggle) begin
      w_next_state  = ST_BT_HOLD;
      w_next_motion = w_bt.motion;
      w_load        = 1'b1;
      w_load_val    = BT_LOAD;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_next_motion = MOT_STOP;
          if (auto_en) begin
            w_next_state  = ST_AUTO;
            w_next_motion = auto_cmd;
          end
        end
        ST_AUTO: begin
          if (auto_en) begin
            w_next_motion = auto_cmd;
          end else begin
            w_next_state  = ST_IDLE;
            w_next_motion = MOT_STOP;
          end
        end
        ST_BT_HOLD, ST_IR_HOLD: begin
          w_dec = 1'b1;
          if ((r_state == ST_IR_HOLD) && ir_repeat_en) begin
            w_load     = 1'b1;
            w_load_val = IR_LOAD;
          end else if (w_expired) begin
            w_next_state  = auto_en ? ST_AUTO : ST_IDLE;
            w_next_motion = auto_en ? auto_cmd : MOT_STOP;
          end
        end
        default: begin
          w_next_state  = ST_IDLE;
          w_next_motion = MOT_STOP;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_motion <= MOT_STOP;
      r_strobe <= 1'b0;
      r_sg90   <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_motion <= w_next_motion;
      r_strobe <= (w_next_motion != r_motion) || (w_next_state != r_state);
      r_sg90   <= w_next_sg90;
    end
  end

  assign motion_cmd = r_motion;
  assign cmd_src    = r_state;
  assign cmd_strobe = r_strobe;
  assign sg90_en    = r_sg90;

endmodule

// File: tb/tb_robot_cmd_arbiter.sv
// Scoreboard bench for robot_cmd_arbiter: a deadline-based ownership model
// predicts each post-edge output and a negedge monitor compares it.
module tb_robot_cmd_arbiter;

  localparam int CLK_FREQ = 1000;
  localparam int IR_MS    = 5;
  localparam int BT_MS    = 12;
  localparam int IR_CYC   = CLK_FREQ / 1000 * IR_MS;
  localparam int BT_CYC   = CLK_FREQ / 1000 * BT_MS;

  logic       clk;
  logic       rst_n;
  logic [7:0] ir_data;
  logic       ir_data_en;
  logic       ir_repeat_en;
  logic [7:0] bt_code;
  logic       bt_valid;
  logic       auto_en;
  logic [3:0] auto_cmd;
  logic [3:0] motion_cmd;
  logic [1:0] cmd_src;
  logic       cmd_strobe;
  logic       sg90_en;

  robot_cmd_arbiter #(
    .CLK_FREQ   (CLK_FREQ),
    .IR_HOLD_MS (IR_MS),
    .BT_HOLD_MS (BT_MS),
    .TMR_W      (26)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ir_data      (ir_data),
    .ir_data_en   (ir_data_en),
    .ir_repeat_en (ir_repeat_en),
    .bt_code      (bt_code),
    .bt_valid     (bt_valid),
    .auto_en      (auto_en),
    .auto_cmd     (auto_cmd),
    .motion_cmd   (motion_cmd),
    .cmd_src      (cmd_src),
    .cmd_strobe   (cmd_strobe),
    .sg90_en      (sg90_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [3:0] motion;
    logic [1:0] src;
    logic       strobe;
    logic       sg;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: owner 0 none, 1 auto, 2 bt, 3 ir; hold ends at an absolute edge number.
  int         m_owner = 0;
  logic [3:0] m_cmd   = 4'd0;
  int         m_end   = 0;
  logic       m_sg    = 1'b0;

  logic [7:0] ir_keys [6] = '{8'h1C, 8'h18, 8'h52, 8'h08, 8'h5A, 8'h45};
  string      bt_keys = "SFBLRP";
  string      bt_junk = "SFBLRPZ";

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Index equals the motion code for 0..4; index 5 is the servo toggle; -1 is unknown.
  function automatic int ir_lookup(input logic [7:0] b);
    for (int i = 0; i < 6; i++) if (ir_keys[i] == b) return i;
    return -1;
  endfunction

  function automatic int bt_lookup(input logic [7:0] b);
    for (int i = 0; i < 6; i++) if (8'(bt_keys[i]) == b) return i;
    return -1;
  endfunction

  task automatic model_step(input int k, input logic ie, input logic [7:0] id,
                            input logic re, input logic bv, input logic [7:0] bc,
                            input logic aen, input logic [3:0] acmd);
    int         prev_owner;
    logic [3:0] prev_cmd;
    int         ir_i;
    int         bt_i;
    bit         ir_ok;
    bit         bt_ok;
    bit         took;
    exp_t       e;
    prev_owner = m_owner;
    prev_cmd   = m_cmd;
    ir_i  = ie ? ir_lookup(id) : -1;
    ir_ok = (ir_i >= 0);
    bt_i  = bv ? bt_lookup(bc) : -1;
    bt_ok = (bt_i >= 0) && !ir_ok && (m_owner != 3);
    took  = 0;
    if (ir_ok && ir_i < 5) begin
      m_owner = 3; m_cmd = 4'(ir_i); m_end = k + IR_CYC; took = 1;
    end else if (bt_ok && bt_i < 5) begin
      m_owner = 2; m_cmd = 4'(bt_i); m_end = k + BT_CYC; took = 1;
    end
    if ((ir_ok && ir_i == 5) || (bt_ok && bt_i == 5)) m_sg = !m_sg;
    if (!took) begin
      if (m_owner == 3 && re) m_end = k + IR_CYC;
      else if (m_owner >= 2 && k >= m_end) m_owner = aen ? 1 : 0;
      else if (m_owner == 0 && aen) m_owner = 1;
      else if (m_owner == 1 && !aen) m_owner = 0;
      if (m_owner == 1) m_cmd = acmd;
      if (m_owner == 0) m_cmd = 4'd0;
    end
    e.due    = k;
    e.motion = m_cmd;
    e.src    = 2'(m_owner);
    e.strobe = (m_cmd != prev_cmd) || (m_owner != prev_owner);
    e.sg     = m_sg;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      check("motion_cmd", motion_cmd, e.motion);
      check("cmd_src",    cmd_src,    e.src);
      check("cmd_strobe", cmd_strobe, e.strobe);
      check("sg90_en",    sg90_en,    e.sg);
    end
  end

  // Called at posedge+1: presents one cycle of inputs, predicts the next edge.
  task automatic drive(input logic ie, input logic [7:0] id, input logic re,
                       input logic bv, input logic [7:0] bc);
    ir_data_en = ie; ir_data = id; ir_repeat_en = re;
    bt_valid = bv;   bt_code = bc;
    model_step(cyc + 1, ie, id, re, bv, bc, auto_en, auto_cmd);
    @(posedge clk); #1;
    ir_data_en = 1'b0; ir_repeat_en = 1'b0; bt_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_motion"}, motion_cmd, 0);
    check({tag, "_src"},    cmd_src,    0);
    check({tag, "_strobe"}, cmd_strobe, 0);
    check({tag, "_sg90"},   sg90_en,    0);
  endtask

  initial begin
    rst_n = 1'b0; ir_data = 8'h00; ir_data_en = 1'b0; ir_repeat_en = 1'b0;
    bt_code = 8'h00; bt_valid = 1'b0; auto_en = 1'b0; auto_cmd = 4'd0;
    repeat (2) @(negedge clk);
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("after_reset");

    // IR forward, no repeats: released after exactly IR_CYC cycles.
    drive(1'b1, 8'h18, 1'b0, 1'b0, 8'h00);
    idle(IR_CYC + 3);

    // IR forward kept alive by repeats every 4 cycles.
    drive(1'b1, 8'h18, 1'b0, 1'b0, 8'h00);
    for (int r = 0; r < 3; r++) begin
      idle(3);
      drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    end
    idle(IR_CYC + 3);

    // BT 'L', then IR right and BT 'B' together; autonomous takes over after timeout.
    drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h4C);
    idle(2);
    auto_en = 1'b1; auto_cmd = 4'd2;
    drive(1'b1, 8'h5A, 1'b0, 1'b1, 8'h42);
    idle(IR_CYC + 3);
    auto_en = 1'b0;
    idle(2);

    // Servo toggle by IR frame only, then BT 'P' toggles it back.
    drive(1'b1, 8'h45, 1'b0, 1'b0, 8'h00);
    for (int r = 0; r < 3; r++) drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    idle(2);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h50);
    idle(2);

    // Unknown bytes, BT hold with servo on, then asynchronous reset mid-hold.
    drive(1'b1, 8'h99, 1'b0, 1'b1, 8'h5A);
    idle(2);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h46);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h50);
    idle(3);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    m_owner = 0; m_cmd = 4'd0; m_sg = 1'b0; m_end = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomised traffic across all sources.
    for (int n = 0; n < 1500; n++) begin
      logic       ie, re, bv;
      logic [7:0] id, bc;
      if ($urandom_range(0, 19) == 0) auto_en = ~auto_en;
      auto_cmd = 4'($urandom_range(0, 15));
      ie = ($urandom_range(0, 9) == 0);
      id = ($urandom_range(0, 9) < 7) ? ir_keys[$urandom_range(0, 5)] : 8'($urandom);
      re = ($urandom_range(0, 4) == 0);
      bv = ($urandom_range(0, 5) == 0);
      bc = ($urandom_range(0, 9) < 7) ? 8'(bt_junk[$urandom_range(0, 6)]) : 8'($urandom);
      drive(ie, id, re, bv, bc);
    end

    repeat (2) @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
